qq_value_router: RTL and testbench
==================================

// Module: qq_value_router
// PURPOSE
// Parametrised successor router for the QuickQ hybrid register/RAM priority queue.
// On a pop, the head entry held in the register stage is compared with the next entry
// fetched from the RAM stage. The winning entry (by key and mode) is routed to the
// output with a valid/ready handshake; the losing entry is fed back to refill the register.
// Adds configurable widths, min/max mode, RAM read latency, empty handling and backpressure.
// PARAMETERS
// KEY_W    16  unsigned priority-key width (key = entry MSBs)
// VAL_W    16  payload width (entry LSBs); ENTRY_W = KEY_W+VAL_W
// MODE_MIN 1   1: smaller key wins (min-queue); 0: larger key wins (max-queue)
// RAM_LAT  1   cycles from ram_rd_en to ram_data valid; legal range 1..4
// PORTS
// clk        in   1        rising-edge clock
// rst_n      in   1        asynchronous active-low reset
// pop_req    in   1        request one dequeue; sampled only in IDLE
// busy       out  1        high whenever state != IDLE
// pop_err    out  1        1-cycle pulse: pop_req with both sources empty
// reg_valid  in   1        register stage holds an entry
// reg_data   in   ENTRY_W  register-stage entry
// ram_empty  in   1        RAM stage holds no entry
// ram_rd_en  out  1        RAM read strobe (1 cycle)
// ram_data   in   ENTRY_W  RAM read data, valid RAM_LAT cycles after ram_rd_en
// out_valid  out  1        data_out valid
// out_ready  in   1        consumer accepts data_out
// data_out   out  ENTRY_W  winning entry
// fb_valid   out  1        1-cycle pulse: register stage must update
// fb_occ     out  1        with fb_valid: register stays occupied (1) or becomes empty (0)
// fb_data    out  ENTRY_W  losing entry to write back (don't-care when fb_occ=0)
// BEHAVIOUR
// - Reset: state=IDLE; busy, pop_err, ram_rd_en, out_valid, fb_valid, fb_occ = 0;
//   data_out and fb_data = 0; the latency counter is cleared.
// - States: IDLE, FETCH, CMP, HOLD.
// - IDLE with pop_req (cycle T):
//   - both empty: pop_err=1 at T+1; stay in IDLE.
//   - RAM empty, reg valid: go to HOLD; data_out=reg_data; at T+1 out_valid=1,
//     fb_valid=1, fb_occ=0.
//   - RAM non-empty: ram_rd_en=1 at T (combinational from IDLE & pop_req & !ram_empty);
//     go to FETCH.
// - FETCH: counter counts RAM_LAT-1 cycles, then enters CMP in the cycle ram_data is valid.
// - CMP: if reg invalid, winner=ram_data and fb_valid/fb_occ=0. Otherwise compare keys:
//   winner goes to data_out, loser to fb_data, fb_occ=1. Ties go to the register entry.
//   Results are registered; out_valid=1 and a fb_valid pulse occur at T+RAM_LAT+1. Go to HOLD.
// - HOLD: data_out is stable while out_valid & !out_ready. On out_ready, out_valid drops
//   next cycle and the FSM returns to IDLE. Next pop is accepted the cycle after the handshake.
// - fb_valid is exactly one cycle per successful pop, never repeated while stalled in HOLD.
// - pop_req outside IDLE is ignored (no queueing, no error).
// - reg_data/reg_valid are sampled in CMP (RAM path) or in IDLE (reg-only path).
//   The caller holds them stable while busy.
// - Reset mid-operation returns to IDLE immediately. Any in-flight RAM data is ignored.
//   No fb_valid or out_valid is produced for the aborted pop.
// - Keys are compared as unsigned KEY_W values; payload never affects ordering.
// STRUCTURE
// - qq_pkg: state enum typedef (qq_rtr_state_t), RAM_LAT_MAX=4 constant, key-extract function.
// - Sub-module qq_key_cmp (combinational; KEY_W, VAL_W, MODE_MIN). Inputs: entries a(reg), b(ram).
//   Outputs: win, lose; tie selects a.
// - Top: FSM, latency counter ($clog2(RAM_LAT_MAX+1) bits), output and feedback registers.
// TESTING
// 1. Reset: assert rst_n=0 mid-HOLD -> all outputs 0 next edge; pop with RAM data
//    after release -> no stale out_valid.
// 2. MODE_MIN=1, reg key 0x0005, RAM key 0x0003, RAM_LAT=1; pop at T ->
//    ram_rd_en@T, out_valid@T+2 with key 3, fb_valid pulse, fb_data key 5, fb_occ=1.
// 3. MODE_MIN=0, same keys -> data_out key 5, fb_data key 3; tie 0x0007/0x0007 ->
//    data_out = reg entry (payload check).
// 4. ram_empty=1, reg_valid=1 -> out_valid@T+1 = reg_data, fb_occ=0, no ram_rd_en;
//    both empty -> pop_err pulse@T+1, busy stays 0.
// 5. Backpressure: out_ready=0 for 5 cycles -> data_out stable, single fb_valid pulse,
//    pop_req during HOLD ignored.
// 6. RAM_LAT=3 sweep with random keys vs scoreboard model -> out_valid@T+4, correct
//    winner/loser every pop.

Source files
------------

// File: rtl/qq_pkg.sv
// Shared types and helpers for the QuickQ successor router.
package qq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCmp,
        StHold
    } qq_rtr_state_t;

    localparam int unsigned RAM_LAT_MAX    = 4;
    localparam int unsigned QQ_MAX_ENTRY_W = 128;

    // Key sits in the entry MSBs; callers zero-extend the entry and truncate the result.
    function automatic logic [63:0] qq_key(input logic [QQ_MAX_ENTRY_W-1:0] entry,
                                           input int unsigned val_w);
        return 64'(entry >> val_w);
    endfunction

endpackage

// File: rtl/qq_value_router_if.sv
// Pop request, register/RAM stage, output and feedback signals of the successor router.
interface qq_value_router_if #(
    parameter int unsigned ENTRY_W = 32
);
    logic               pop_req;
    logic               busy;
    logic               pop_err;
    logic               reg_valid;
    logic [ENTRY_W-1:0] reg_data;
    logic               ram_empty;
    logic               ram_rd_en;
    logic [ENTRY_W-1:0] ram_data;
    logic               out_valid;
    logic               out_ready;
    logic [ENTRY_W-1:0] data_out;
    logic               fb_valid;
    logic               fb_occ;
    logic [ENTRY_W-1:0] fb_data;

    modport master (
        output pop_req, reg_valid, reg_data, ram_empty, ram_data, out_ready,
        input  busy, pop_err, ram_rd_en, out_valid, data_out, fb_valid, fb_occ, fb_data
    );

    modport slave (
        input  pop_req, reg_valid, reg_data, ram_empty, ram_data, out_ready,
        output busy, pop_err, ram_rd_en, out_valid, data_out, fb_valid, fb_occ, fb_data
    );
endinterface

// File: rtl/qq_key_cmp.sv
// Combinational winner/loser select between the register entry (a) and RAM entry (b).
module qq_key_cmp
    import qq_pkg::*;
#(
    parameter int unsigned KEY_W    = 16,
    parameter int unsigned VAL_W    = 16,
    parameter bit          MODE_MIN = 1'b1
) (
    input  logic [KEY_W+VAL_W-1:0] a,
    input  logic [KEY_W+VAL_W-1:0] b,
    output logic [KEY_W+VAL_W-1:0] win,
    output logic [KEY_W+VAL_W-1:0] lose
);

    logic [KEY_W-1:0] key_a;
    logic [KEY_W-1:0] key_b;
    logic             b_wins;

    assign key_a = KEY_W'(qq_key(QQ_MAX_ENTRY_W'(a), VAL_W));
    assign key_b = KEY_W'(qq_key(QQ_MAX_ENTRY_W'(b), VAL_W));

    // Strict compare so that equal keys keep the register entry in front.
    assign b_wins = MODE_MIN ? (key_b < key_a) : (key_b > key_a);

    assign win  = b_wins ? b : a;
    assign lose = b_wins ? a : b;

endmodule

// File: rtl/qq_value_router.sv
// Routes the winning head/successor entry to the output and feeds the loser back.
module qq_value_router
    import qq_pkg::*;
#(
    parameter int unsigned KEY_W    = 16,
    parameter int unsigned VAL_W    = 16,
    parameter bit          MODE_MIN = 1'b1,
    parameter int unsigned RAM_LAT  = 1
) (
    input logic               clk,
    input logic               rst_n,
    qq_value_router_if.slave  bus
);

    localparam int unsigned ENTRY_W = KEY_W + VAL_W;
    localparam int unsigned CNT_W   = $clog2(RAM_LAT_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RAM_LAT - 1);

    qq_rtr_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ENTRY_W-1:0] data_out_q, data_out_d;
    logic               fb_valid_q, fb_valid_d;
    logic               fb_occ_q, fb_occ_d;
    logic [ENTRY_W-1:0] fb_data_q, fb_data_d;
    logic               pop_err_q, pop_err_d;
    logic               ram_rd_en;
    logic [ENTRY_W-1:0] cmp_win;
    logic [ENTRY_W-1:0] cmp_lose;

    qq_key_cmp #(
        .KEY_W    (KEY_W),
        .VAL_W    (VAL_W),
        .MODE_MIN (MODE_MIN)
    ) u_key_cmp (
        .a    (bus.reg_data),
        .b    (bus.ram_data),
        .win  (cmp_win),
        .lose (cmp_lose)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        fb_valid_d  = 1'b0;
        fb_occ_d    = 1'b0;
        fb_data_d   = fb_data_q;
        pop_err_d   = 1'b0;
        ram_rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.pop_req) begin
                    if (!bus.ram_empty) begin
                        ram_rd_en = 1'b1;
                        cnt_d     = CNT_W'(1);
                        // With single-cycle RAM the data is already valid next cycle.
                        state_d   = (RAM_LAT == 1) ? StCmp : StFetch;
                    end else if (bus.reg_valid) begin
                        data_out_d  = bus.reg_data;
                        out_valid_d = 1'b1;
                        fb_valid_d  = 1'b1;
                        state_d     = StHold;
                    end else begin
                        pop_err_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = StCmp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCmp: begin
                out_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = StHold;
                if (bus.reg_valid) begin
                    data_out_d = cmp_win;
                    fb_data_d  = cmp_lose;
                    fb_valid_d = 1'b1;
                    fb_occ_d   = 1'b1;
                end else begin
                    data_out_d = bus.ram_data;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            fb_valid_q  <= 1'b0;
            fb_occ_q    <= 1'b0;
            fb_data_q   <= '0;
            pop_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            fb_valid_q  <= fb_valid_d;
            fb_occ_q    <= fb_occ_d;
            fb_data_q   <= fb_data_d;
            pop_err_q   <= pop_err_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.pop_err   = pop_err_q;
    assign bus.ram_rd_en = ram_rd_en;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.fb_valid  = fb_valid_q;
    assign bus.fb_occ    = fb_occ_q;
    assign bus.fb_data   = fb_data_q;

endmodule

// File: tb/tb_qq_value_router.sv
// Directed vector bench for qq_value_router: min/max modes, RAM latency 1 and 3.
module tb_qq_value_router;

    typedef struct packed {
        logic        busy;
        logic        pop_err;
        logic        ram_rd_en;
        logic        out_valid;
        logic [31:0] data_out;
        logic        fb_valid;
        logic        fb_occ;
        logic [31:0] fb_data;
    } obs_t;

    typedef struct {
        int          sel;
        logic        reg_valid;
        logic [31:0] reg_data;
        logic        ram_empty;
        logic [31:0] ram_word;
        logic [31:0] exp_out;
        logic        exp_fb;
        logic        exp_occ;
        logic [31:0] exp_fbd;
        logic        chk_fbd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  pop_req = '0;
    logic        reg_valid = 1'b0;
    logic [31:0] reg_data = '0;
    logic        ram_empty = 1'b1;
    logic [31:0] ram_word = '0;
    logic [31:0] ram_data;
    logic        out_ready = 1'b0;
    logic [3:0]  rd_pipe;
    logic        ram_hit;
    int          sel = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    obs_t        obs [3];
    vec_t        vecs [12];

    always #5 clk = ~clk;

    // sel 0: min/lat1, sel 1: max/lat1, sel 2: min/lat3
    qq_value_router_if #(.ENTRY_W(32)) if_min ();
    qq_value_router_if #(.ENTRY_W(32)) if_max ();
    qq_value_router_if #(.ENTRY_W(32)) if_l3 ();

    qq_value_router #(.KEY_W(16), .VAL_W(16), .MODE_MIN(1'b1), .RAM_LAT(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .bus(if_min)
    );
    qq_value_router #(.KEY_W(16), .VAL_W(16), .MODE_MIN(1'b0), .RAM_LAT(1)) dut_max (
        .clk(clk), .rst_n(rst_n), .bus(if_max)
    );
    qq_value_router #(.KEY_W(16), .VAL_W(16), .MODE_MIN(1'b1), .RAM_LAT(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .bus(if_l3)
    );

    assign if_min.pop_req = pop_req[0];
    assign if_max.pop_req = pop_req[1];
    assign if_l3.pop_req  = pop_req[2];
    assign if_min.reg_valid = reg_valid;
    assign if_max.reg_valid = reg_valid;
    assign if_l3.reg_valid  = reg_valid;
    assign if_min.reg_data = reg_data;
    assign if_max.reg_data = reg_data;
    assign if_l3.reg_data  = reg_data;
    assign if_min.ram_empty = ram_empty;
    assign if_max.ram_empty = ram_empty;
    assign if_l3.ram_empty  = ram_empty;
    assign if_min.ram_data = ram_data;
    assign if_max.ram_data = ram_data;
    assign if_l3.ram_data  = ram_data;
    assign if_min.out_ready = out_ready;
    assign if_max.out_ready = out_ready;
    assign if_l3.out_ready  = out_ready;

    assign obs[0] = {if_min.busy, if_min.pop_err, if_min.ram_rd_en, if_min.out_valid,
                     if_min.data_out, if_min.fb_valid, if_min.fb_occ, if_min.fb_data};
    assign obs[1] = {if_max.busy, if_max.pop_err, if_max.ram_rd_en, if_max.out_valid,
                     if_max.data_out, if_max.fb_valid, if_max.fb_occ, if_max.fb_data};
    assign obs[2] = {if_l3.busy, if_l3.pop_err, if_l3.ram_rd_en, if_l3.out_valid,
                     if_l3.data_out, if_l3.fb_valid, if_l3.fb_occ, if_l3.fb_data};

    // RAM model: word valid only RAM_LAT cycles after the strobe; a key that would win otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pipe <= '0;
        else        rd_pipe <= {rd_pipe[2:0], obs[sel].ram_rd_en};
    end
    assign ram_hit  = (sel == 2) ? rd_pipe[2] : rd_pipe[0];
    assign ram_data = ram_hit ? ram_word : ((sel == 1) ? 32'hFFFF_EEEE : 32'h0000_EEEE);

    function automatic int lat_of(input int s);
        return (s == 2) ? 3 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_pop(input vec_t v);
        int k;
        int exp_lat;
        logic exp_err;
        exp_err = v.ram_empty && !v.reg_valid;
        exp_lat = v.ram_empty ? 1 : lat_of(v.sel) + 1;
        @(posedge clk); #1;
        sel       = v.sel;
        reg_valid = v.reg_valid;
        reg_data  = v.reg_data;
        ram_empty = v.ram_empty;
        ram_word  = v.ram_word;
        out_ready = 1'b1;
        pop_req[v.sel] = 1'b1;
        @(negedge clk);
        chk("rd_en", 64'(obs[sel].ram_rd_en), 64'(!v.ram_empty));
        @(posedge clk); #1;
        pop_req[v.sel] = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (obs[sel].out_valid || obs[sel].pop_err) break;
            @(posedge clk); #1;
        end
        chk("latency", 64'(k), 64'(exp_lat));
        if (k <= 8) begin
            chk("out_valid", 64'(obs[sel].out_valid), 64'(!exp_err));
            chk("pop_err", 64'(obs[sel].pop_err), 64'(exp_err));
            chk("busy", 64'(obs[sel].busy), 64'(!exp_err));
            chk("fb_valid", 64'(obs[sel].fb_valid), 64'(v.exp_fb));
            if (!exp_err) begin
                chk("data_out", 64'(obs[sel].data_out), 64'(v.exp_out));
                chk("fb_occ", 64'(obs[sel].fb_occ), 64'(v.exp_occ));
            end
            if (v.chk_fbd) chk("fb_data", 64'(obs[sel].fb_data), 64'(v.exp_fbd));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("fb_once", 64'(obs[sel].fb_valid), 64'(0));
        chk("out_drop", 64'(obs[sel].out_valid), 64'(0));
        chk("err_once", 64'(obs[sel].pop_err), 64'(0));
        chk("idle", 64'(obs[sel].busy), 64'(0));
    endtask

    task automatic wait_out_valid(input string name);
        int k;
        for (k = 0; k < 8; k++) begin
            @(negedge clk);
            if (obs[sel].out_valid) break;
            @(posedge clk); #1;
        end
        chk(name, 64'(obs[sel].out_valid), 64'(1));
    endtask

    initial begin
        int fb_cnt;
        int bad;
        vec_t v;
        //              sel rv  reg_data      re   ram_word      exp_out       fb   occ  fbd           chk
        vecs[0]  = '{0, 1'b1, 32'h0005_AAAA, 1'b0, 32'h0003_BBBB, 32'h0003_BBBB, 1'b1, 1'b1, 32'h0005_AAAA, 1'b1};
        vecs[1]  = '{1, 1'b1, 32'h0005_AAAA, 1'b0, 32'h0003_BBBB, 32'h0005_AAAA, 1'b1, 1'b1, 32'h0003_BBBB, 1'b1};
        vecs[2]  = '{1, 1'b1, 32'h0007_1111, 1'b0, 32'h0007_2222, 32'h0007_1111, 1'b1, 1'b1, 32'h0007_2222, 1'b1};
        vecs[3]  = '{0, 1'b1, 32'h0007_1111, 1'b0, 32'h0007_2222, 32'h0007_1111, 1'b1, 1'b1, 32'h0007_2222, 1'b1};
        vecs[4]  = '{0, 1'b1, 32'h1234_5678, 1'b1, 32'h0001_0001, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{0, 1'b0, 32'h0009_0009, 1'b1, 32'h0001_0001, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{0, 1'b0, 32'h0001_0001, 1'b0, 32'h0042_0042, 32'h0042_0042, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[7]  = '{0, 1'b1, 32'h0010_0001, 1'b0, 32'h000F_FFFF, 32'h000F_FFFF, 1'b1, 1'b1, 32'h0010_0001, 1'b1};
        vecs[8]  = '{1, 1'b1, 32'h7FFF_0000, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_0000, 1'b1};
        vecs[9]  = '{2, 1'b1, 32'h0100_0001, 1'b0, 32'h00FF_0002, 32'h00FF_0002, 1'b1, 1'b1, 32'h0100_0001, 1'b1};
        vecs[10] = '{1, 1'b1, 32'h0020_0020, 1'b1, 32'h0001_0001, 32'h0020_0020, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[11] = '{2, 1'b1, 32'h0030_0030, 1'b1, 32'h0001_0001, 32'h0030_0030, 1'b1, 1'b0, 32'h0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset_state", 64'(obs[i]), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("post_reset", 64'(obs[i]), 64'(0));

        for (int i = 0; i < 12; i++) do_pop(vecs[i]);

        // Backpressure: output held, single feedback pulse, pop_req in HOLD ignored.
        @(posedge clk); #1;
        sel = 0; reg_valid = 1'b1; reg_data = 32'h0005_AAAA;
        ram_empty = 1'b0; ram_word = 32'h0003_BBBB; out_ready = 1'b0;
        pop_req[0] = 1'b1;
        @(posedge clk); #1;
        pop_req[0] = 1'b0;
        wait_out_valid("bp_reach");
        fb_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (obs[0].fb_valid) fb_cnt++;
            chk("bp_data", 64'(obs[0].data_out), 64'h0003_BBBB);
            chk("bp_hold_rd", 64'(obs[0].ram_rd_en), 64'(0));
            chk("bp_busy", 64'(obs[0].busy), 64'(1));
            @(posedge clk); #1;
            pop_req[0] = 1'b1;
            @(negedge clk);
        end
        chk("bp_fb_count", 64'(fb_cnt), 64'(1));
        @(posedge clk); #1;
        pop_req[0] = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drop", 64'(obs[0].out_valid), 64'(0));
        chk("bp_no_requeue", 64'(obs[0].busy), 64'(0));

        // Reset while stalled in HOLD.
        @(posedge clk); #1;
        out_ready = 1'b0;
        pop_req[0] = 1'b1;
        @(posedge clk); #1;
        pop_req[0] = 1'b0;
        wait_out_valid("rst_reach_hold");
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hold", 64'(obs[0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (obs[0].out_valid || obs[0].fb_valid || obs[0].busy) bad++;
        end
        chk("rst_no_stale", 64'(bad), 64'(0));
        do_pop(vecs[0]);

        // Reset in the middle of a latency-3 fetch: the aborted pop must stay silent.
        @(posedge clk); #1;
        sel = 2; reg_valid = 1'b1; reg_data = 32'h0005_0005;
        ram_empty = 1'b0; ram_word = 32'h0002_0002; out_ready = 1'b1;
        pop_req[2] = 1'b1;
        @(posedge clk); #1;
        pop_req[2] = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (obs[2].out_valid || obs[2].fb_valid || obs[2].busy) bad++;
        end
        chk("rst_mid_fetch", 64'(bad), 64'(0));

        // Latency-3 sweep with small random keys (ties included) against a min-queue model.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] rk;
            logic [15:0] mk;
            rk = 16'($urandom_range(1, 8));
            mk = 16'($urandom_range(1, 8));
            v.sel = 2; v.reg_valid = 1'b1; v.ram_empty = 1'b0;
            v.reg_data = {rk, 16'($urandom)};
            v.ram_word = {mk, 16'($urandom)};
            v.exp_fb = 1'b1; v.exp_occ = 1'b1; v.chk_fbd = 1'b1;
            if (mk < rk) begin
                v.exp_out = v.ram_word; v.exp_fbd = v.reg_data;
            end else begin
                v.exp_out = v.reg_data; v.exp_fbd = v.ram_word;
            end
            do_pop(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
